// File: rtl/mem_stage_unit.sv
// mem_stage_unit: ME pipeline stage that latches EX results, waits for the data-SRAM load response, and forwards aligned/extended results to WB.
//  clk, reset            : clock, synchronous active-high reset
//  EX_to_ME_Valid/Bus    : incoming instruction {pc, gr_we, dest, res_from_mem, ld_op, req, alu_result}
//  ME_Allow_in           : ME can accept a new instruction this cycle
//  WB_Allow_in           : WB can accept ME output
//  ME_to_WB_Valid/Bus    : outgoing result {pc, gr_we, dest, final_result}
//  data_sram_data_ok/rdata : load response pulse and data
//  ME_dest, ME_Forward_Res : bypass destination and value
//  ME_load_busy          : load still waiting for data (ID load-use interlock)
module mem_stage_unit #(
  parameter int EX_ME_BUS_W = 75,
  parameter int ME_WB_BUS_W = 70
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   EX_to_ME_Valid,
  input  logic [EX_ME_BUS_W-1:0] EX_to_ME_Bus,
  output logic                   ME_Allow_in,
  input  logic                   WB_Allow_in,
  output logic                   ME_to_WB_Valid,
  output logic [ME_WB_BUS_W-1:0] ME_to_WB_Bus,
  input  logic                   data_sram_data_ok,
  input  logic [31:0]            data_sram_rdata,
  output logic [4:0]             ME_dest,
  output logic [31:0]            ME_Forward_Res,
  output logic                   ME_load_busy
);
  logic        me_valid, gr_we, res_from_mem, req, rdata_buf_vld;
  logic [31:0] pc, alu_result, rdata_buf, ld_data, ld_ext, final_result;
  logic [4:0]  dest;
  logic [2:0]  ld_op;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        ready_go, leave;
  // Data arriving this cycle, or already parked in the buffer, lets the load go.
  assign ready_go = !(req && !rdata_buf_vld && !data_sram_data_ok);
  assign leave = me_valid && ready_go && WB_Allow_in;
  assign ME_Allow_in = !me_valid || (ready_go && WB_Allow_in);
  assign ME_to_WB_Valid = me_valid && ready_go;
  assign ld_data = rdata_buf_vld ? rdata_buf : data_sram_rdata;
  assign ld_byte = ld_data[{alu_result[1:0], 3'b000} +: 8];
  assign ld_half = alu_result[1] ? ld_data[31:16] : ld_data[15:0];
  assign ld_ext = (ld_op == 3'b001) ? {{24{ld_byte[7]}}, ld_byte} :
                  (ld_op == 3'b011) ? {24'd0, ld_byte} :
                  (ld_op == 3'b010) ? {{16{ld_half[15]}}, ld_half} :
                  (ld_op == 3'b100) ? {16'd0, ld_half} : ld_data;
  assign final_result = res_from_mem ? ld_ext : alu_result;
  assign ME_to_WB_Bus = {pc, gr_we, dest, final_result};
  assign ME_dest = (me_valid && gr_we) ? dest : 5'd0;
  assign ME_Forward_Res = final_result;
  assign ME_load_busy = me_valid && res_from_mem && !ready_go;
  always_ff @(posedge clk) begin
    if (reset) begin
      me_valid <= 1'b0;
      rdata_buf_vld <= 1'b0;
    end else begin
      if (ME_Allow_in) me_valid <= EX_to_ME_Valid;
      // Leaving wins over capture: data used directly never needs parking.
      if (leave) rdata_buf_vld <= 1'b0;
      else if (data_sram_data_ok && me_valid && req) rdata_buf_vld <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (EX_to_ME_Valid && ME_Allow_in)
      {pc, gr_we, dest, res_from_mem, ld_op, req, alu_result} <= EX_to_ME_Bus;
    if (data_sram_data_ok && me_valid && req && !leave) rdata_buf <= data_sram_rdata;
  end
endmodule

// File: tb/tb_mem_stage_unit.sv
// tb_mem_stage_unit: randomized and directed checks of mem_stage_unit against a per-instruction reference model.
module tb_mem_stage_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic [74:0] ex_bus;
  logic        allow_in;
  logic        wb_allow;
  logic        wb_valid;
  logic [69:0] wb_bus;
  logic        data_ok;
  logic [31:0] rdata;
  logic [4:0]  me_dest;
  logic [31:0] fwd_res;
  logic        load_busy;
  int vectors = 0, errors = 0;
  // Reference model: the one instruction held in ME and whether its load data has been parked.
  logic        m_valid = 1'b0, m_have = 1'b0, m_we, m_rfm, m_req;
  logic [31:0] m_pc, m_alu, m_data;
  logic [4:0]  m_dest;
  logic [2:0]  m_op;
  int          m_dly = 0;
  always #5 clk = ~clk;
  mem_stage_unit dut (
    .clk(clk), .reset(reset),
    .EX_to_ME_Valid(ex_valid), .EX_to_ME_Bus(ex_bus), .ME_Allow_in(allow_in),
    .WB_Allow_in(wb_allow), .ME_to_WB_Valid(wb_valid), .ME_to_WB_Bus(wb_bus),
    .data_sram_data_ok(data_ok), .data_sram_rdata(rdata),
    .ME_dest(me_dest), .ME_Forward_Res(fwd_res), .ME_load_busy(load_busy)
  );
  task automatic chk(input string tag, input logic [69:0] got, input logic [69:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [74:0] mk(input logic [31:0] pc, input logic we, input logic [4:0] dest,
                                     input logic rfm, input logic [2:0] op, input logic req, input logic [31:0] alu);
    return {pc, we, dest, rfm, op, req, alu};
  endfunction
  // Load extraction written arithmetically: shift the word down to the addressed lane, then extend.
  function automatic logic [31:0] extract(input logic [2:0] op, input logic [1:0] a, input logic [31:0] d);
    longint b, h;
    b = (longint'(d) >> (8 * a)) % 256;
    h = a[1] ? longint'(d) / 65536 : longint'(d) % 65536;
    case (op)
      3'd1: return 32'(b >= 128 ? b - 256 : b);
      3'd3: return 32'(b);
      3'd2: return 32'(h >= 32768 ? h - 65536 : h);
      3'd4: return 32'(h);
      default: return d;
    endcase
  endfunction
  // One clock: drive inputs after the falling edge, check combinational outputs, advance the model.
  task automatic step(input logic r, input logic ev, input logic [74:0] bus, input logic wb,
                      input logic dok, input logic [31:0] rd);
    logic ready, allow, fire;
    logic [31:0] res;
    @(negedge clk);
    reset = r; ex_valid = ev; ex_bus = bus; wb_allow = wb; data_ok = dok; rdata = rd;
    #1;
    if (r) begin
      m_valid = 1'b0;
      m_have = 1'b0;
      return;
    end
    ready = !(m_valid && m_req && !m_have && !dok);
    allow = !m_valid || (ready && wb);
    fire = m_valid && ready && wb;
    chk("allow_in", allow_in, allow);
    chk("wb_valid", wb_valid, m_valid && ready);
    chk("load_busy", load_busy, m_valid && m_rfm && !ready);
    chk("me_dest", me_dest, (m_valid && m_we) ? m_dest : 5'd0);
    if (m_valid && ready) begin
      res = m_rfm ? extract(m_op, m_alu[1:0], m_have ? m_data : rd) : m_alu;
      chk("wb_bus", wb_bus, {m_pc, m_we, m_dest, res});
      chk("fwd_res", fwd_res, res);
    end
    if (dok && m_valid && m_req && !fire) begin
      m_have = 1'b1;
      m_data = rd;
    end
    if (fire) m_have = 1'b0;
    if (allow) begin
      if (ev) begin
        {m_pc, m_we, m_dest, m_rfm, m_op, m_req, m_alu} = bus;
        m_dly = $urandom_range(0, 3);
      end
      m_valid = ev;
    end else if (m_dly > 0) m_dly--;
  endtask
  initial begin
    logic [74:0] b;
    logic req, rfm, dok;
    step(1, 0, '0, 1, 0, 0);
    step(1, 0, '0, 1, 0, 0);
    step(0, 0, '0, 1, 0, 0);
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_allow", allow_in, 1'b1);
    chk("rst_busy", load_busy, 1'b0);
    chk("rst_dest", me_dest, 5'd0);
    // ALU op passes through in one cycle.
    step(0, 1, mk(32'h1C000000, 1, 5, 0, 0, 0, 32'h12345678), 1, 0, 0);
    step(0, 0, '0, 1, 0, 0);
    chk("t1_res", wb_bus[31:0], 32'h12345678);
    chk("t1_dest", me_dest, 5'd5);
    // ld.b at byte 3, data two cycles late.
    step(0, 1, mk(32'h1C000004, 1, 6, 1, 3'd1, 1, 32'h00001003), 1, 0, 0);
    step(0, 0, '0, 1, 0, 0);
    chk("t2_busy", load_busy, 1'b1);
    chk("t2_allow", allow_in, 1'b0);
    step(0, 0, '0, 1, 0, 0);
    step(0, 0, '0, 1, 1, 32'h80FF7F01);
    chk("t2_res", wb_bus[31:0], 32'hFFFFFF80);
    // ld.hu upper half, data arrives while WB stalls and is buffered.
    step(0, 1, mk(32'h1C000008, 1, 7, 1, 3'd4, 1, 32'h00002002), 1, 0, 0);
    step(0, 0, '0, 0, 1, 32'hBEEF1234);
    step(0, 0, '0, 0, 0, 32'h11111111);
    step(0, 0, '0, 0, 0, 32'h22222222);
    step(0, 0, '0, 1, 0, 32'h33333333);
    chk("t3_res", wb_bus[31:0], 32'h0000BEEF);
    step(0, 0, '0, 1, 0, 0);
    chk("t3_once", wb_valid, 1'b0);
    // Back-to-back ALU ops with WB toggling.
    step(0, 1, mk(32'h1C000010, 1, 1, 0, 0, 0, 32'hA), 1, 0, 0);
    step(0, 1, mk(32'h1C000014, 1, 2, 0, 0, 0, 32'hB), 0, 0, 0);
    step(0, 1, mk(32'h1C000018, 1, 3, 0, 0, 0, 32'hC), 1, 0, 0);
    step(0, 0, '0, 1, 0, 0);
    step(0, 0, '0, 1, 0, 0);
    // Reset while a load waits; stray data_ok afterwards is ignored.
    step(0, 1, mk(32'h1C000020, 1, 4, 1, 3'd0, 1, 32'h100), 1, 0, 0);
    step(0, 0, '0, 1, 0, 0);
    step(1, 0, '0, 1, 0, 0);
    step(0, 0, '0, 1, 1, 32'hDEADBEEF);
    chk("t5_wb_valid", wb_valid, 1'b0);
    chk("t5_allow", allow_in, 1'b1);
    step(0, 1, mk(32'h1C000024, 1, 4, 1, 3'd0, 1, 32'h104), 1, 0, 0);
    step(0, 0, '0, 1, 0, 0);
    chk("t5_buf_clear", load_busy, 1'b1);
    step(0, 0, '0, 1, 1, 32'h5);
    // gr_we=0 hides dest; ld.w with same-cycle data.
    step(0, 1, mk(32'h1C000030, 0, 7, 0, 0, 0, 32'h77), 1, 0, 0);
    step(0, 1, mk(32'h1C000034, 1, 9, 1, 3'd0, 1, 32'h200), 1, 0, 0);
    chk("t6_dest", me_dest, 5'd0);
    step(0, 0, '0, 1, 1, 32'hCAFEF00D);
    chk("t6_res", wb_bus[31:0], 32'hCAFEF00D);
    // Random traffic with a memory that answers 0..3 cycles after entry.
    for (int i = 0; i < 3000; i++) begin
      req = ($urandom_range(0, 2) != 0);
      rfm = req && ($urandom_range(0, 3) != 0);
      b = mk($urandom, 1'($urandom), 5'($urandom), rfm, 3'($urandom), req, $urandom);
      dok = m_valid && m_req && !m_have && m_dly == 0;
      if (!(m_valid && m_req) && $urandom_range(0, 19) == 0) dok = 1'b1;
      step($urandom_range(0, 199) == 0, 1'($urandom), b, $urandom_range(0, 3) != 0, dok, $urandom);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
